// File: rtl/shift_mac_pkg.sv
// Shared definitions for the shift-accumulate processing element.
//   - Weight-code layout: code = {zero, sign, shift[SHIFT_W-1:0]}.
//     The shift field starts at SHIFT_LSB. ZERO_BIT and SIGN_BIT are offsets
//     above the shift field, so the absolute index is SHIFT_W + offset.
//   - Result-buffer state enum.
//   - sat_add: width-parameterised add with optional saturation, computed on
//     a wide internal word so any ACC_W up to ADD_W-1 fits.
package shift_mac_pkg;

  localparam int SHIFT_LSB = 0;
  localparam int SIGN_BIT  = 0;
  localparam int ZERO_BIT  = 1;

  localparam int ADD_W = 64;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  typedef struct packed {
    logic signed [ADD_W-1:0] sum;
    logic                    clamp;
  } add_res_t;

  // Operands arrive sign-extended to ADD_W. With sat=0 the caller keeps only
  // the low 'width' bits, which gives two's-complement wrap for free.
  function automatic add_res_t sat_add(input logic signed [ADD_W-1:0] a,
                                       input logic signed [ADD_W-1:0] b,
                                       input int                      width,
                                       input logic                    sat);
    add_res_t r;
    logic signed [ADD_W:0] full;
    logic signed [ADD_W:0] max_v;
    logic signed [ADD_W:0] min_v;
    full  = {a[ADD_W-1], a} + {b[ADD_W-1], b};
    max_v = ((ADD_W+1)'(1) << (width - 1)) - (ADD_W+1)'(1);
    min_v = ~max_v;
    r.sum   = full[ADD_W-1:0];
    r.clamp = 1'b0;
    if (sat) begin
      if (full > max_v) begin
        r.sum   = max_v[ADD_W-1:0];
        r.clamp = 1'b1;
      end else if (full < min_v) begin
        r.sum   = min_v[ADD_W-1:0];
        r.clamp = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_mac_pe_pow2_mul.sv
// pow2_mul: combinational power-of-two "multiplier".
// Ports:
//   code    [SHIFT_W+2] weight code {zero, sign, shift}
//   act     [DATA_W]    signed activation
//   product [ACC_W]     signed product: 0, +(act<<shift) or -(act<<shift)
// ACC_W >= DATA_W + 2^SHIFT_W - 1 keeps the shifted value exact.
module pow2_mul
  import shift_mac_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 3,
  parameter int ACC_W   = 16
) (
  input  logic        [SHIFT_W+1:0] code,
  input  logic signed [DATA_W-1:0]  act,
  output logic signed [ACC_W-1:0]   product
);

  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    ext     = {{(ACC_W-DATA_W){act[DATA_W-1]}}, act};
    shifted = ext << code[SHIFT_LSB +: SHIFT_W];
    product = shifted;
    if (code[SHIFT_W + ZERO_BIT]) begin
      product = '0;
    end else if (code[SHIFT_W + SIGN_BIT]) begin
      product = -shifted;
    end
  end

endmodule

// File: rtl/shift_mac_pe.sv
// shift_mac_pe: systolic processing element with shift-based MAC.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid, in_last     beat qualifier / end-of-vector marker
//   up_in, left_in        weight code and activation entering the PE
//   out_valid, out_last   one-cycle-delayed in_valid / in_last
//   up_out, left_out      one-cycle-delayed up_in / left_in (always forwarded)
//   res_valid, res_ready  result-buffer handshake
//   res_data, res_sat     completed dot product and its saturation flag
//   err_overrun           sticky: an unread result was overwritten
// The one-entry result buffer loads on the edge that samples a last beat,
// so the next vector can accumulate while the previous result drains.
module shift_mac_pe
  import shift_mac_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 3,
  parameter int ACC_W   = 16,
  parameter int SAT     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic        [SHIFT_W+1:0] up_in,
  input  logic signed [DATA_W-1:0]  left_in,
  output logic                      out_valid,
  output logic                      out_last,
  output logic        [SHIFT_W+1:0] up_out,
  output logic signed [DATA_W-1:0]  left_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [ACC_W-1:0]   res_data,
  output logic                      res_sat,
  output logic                      err_overrun
);

  logic signed [ACC_W-1:0] product;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic                    clamp;
  logic                    sat_run;
  logic                    last_beat;
  add_res_t                add_r;
  logic                    unused_add_hi;
  res_state_e              state;
  res_state_e              state_next;

  pow2_mul #(
    .DATA_W (DATA_W),
    .SHIFT_W(SHIFT_W),
    .ACC_W  (ACC_W)
  ) u_mul (
    .code   (up_in),
    .act    (left_in),
    .product(product)
  );

  assign last_beat = in_valid && in_last;
  assign res_valid = (state == RES_FULL);

  always_comb begin
    add_r = sat_add(ADD_W'(acc), ADD_W'(product), ACC_W, SAT != 0);
    sum   = add_r.sum[ACC_W-1:0];
    clamp = add_r.clamp;
  end

  // Upper bits of the wide adder word are redundant once truncated to ACC_W.
  assign unused_add_hi = ^add_r.sum[ADD_W-1:ACC_W];

  // Payload is forwarded every cycle regardless of in_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      up_out    <= '0;
      left_out  <= '0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_last;
      up_out    <= up_in;
      left_out  <= left_in;
    end
  end

  // A last beat closes the vector: the accumulator restarts from zero so the
  // next vector can begin on the very next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      sat_run <= 1'b0;
    end else if (in_valid) begin
      if (in_last) begin
        acc     <= '0;
        sat_run <= 1'b0;
      end else begin
        acc     <= sum;
        sat_run <= sat_run | clamp;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data    <= '0;
      res_sat     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (last_beat) begin
        res_data <= sum;
        res_sat  <= sat_run | clamp;
      end
      // A simultaneous res_ready means the old result was taken this edge.
      if (state == RES_FULL && last_beat && !res_ready) begin
        err_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RES_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RES_EMPTY: if (last_beat) state_next = RES_FULL;
      RES_FULL:  if (!last_beat && res_ready) state_next = RES_EMPTY;
      default:   state_next = RES_EMPTY;
    endcase
  end

endmodule
